uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
- Serial UART transmitter, 8N1 by default with optional parity; the counterpart of the team's UART receiver (RX/data/done/err/busy interface).
- Accepts a parallel byte via a start strobe and shifts it out LSB-first on TX at a fixed baud derived from the system clock.
- Sits between host logic (register file / FIFO) and the board TX pin; in the loopback bench TX drives the receiver's RX directly.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, line rate in bits/s; BIT_PERIOD = CLK_FREQ/BAUD (integer division, 10416 at defaults).
- PARITY_EN, 0, 1 inserts a parity bit between data bit 7 and the stop bit.
- PARITY_ODD, 0, parity sense when PARITY_EN=1: 0 = even, 1 = odd.

Ports:
- clk  input  1  system clock, rising edge.
- arst_n  input  1  asynchronous active-low reset.
- rst  input  1  synchronous active-high reset, same effect as arst_n but takes effect at the next clk edge.
- tx_en  input  1  transmitter enable; gates acceptance of new frames only.
- tx_start  input  1  request to send data; sampled each cycle.
- data  input  8  byte to send; captured on the acceptance cycle.
- TX  output  1  serial line; idle high.
- busy  output  1  high while a frame is in progress.
- done  output  1  single-cycle pulse at frame completion.

Behaviour:
- Reset (arst_n low, or rst high at an edge): state IDLE; TX=1, busy=0, done=0; baud counter, bit index, shift register cleared. Reset mid-frame aborts immediately. TX returns high and no done pulse is issued.
- States: IDLE -> START -> DATA -> (PARITY if PARITY_EN) -> STOP -> IDLE.
- Acceptance: in IDLE, tx_start=1 and tx_en=1 at edge N -> data latched into the shift register. Parity is computed from the latched byte. At edge N, state becomes START, busy=1 and TX=0.
- tx_start while busy, or while tx_en=0, is ignored. There is no queuing.
- Each bit (start, 8 data, parity, stop) holds TX for exactly BIT_PERIOD clocks. The baud counter runs 0..BIT_PERIOD-1 and reloads to 0 on each bit boundary.
- DATA: bit index 0..7; TX = shift[0]; the register shifts right at each bit boundary. After bit 7, go to PARITY or STOP.
- PARITY: TX = ^data XOR PARITY_ODD.
- STOP: TX=1 for BIT_PERIOD clocks. At the final count: state becomes IDLE, busy=0, and done=1 for exactly one cycle.
- Frame length: 10*BIT_PERIOD clocks (11 with parity), measured from the first TX=0 cycle to the busy fall.
- Back-to-back: tx_start held high through the done cycle is accepted in that IDLE cycle. The next start bit begins the following edge, leaving no idle gap beyond one clock.
- tx_en deasserted mid-frame: the current frame completes normally; only new acceptances are blocked.
- Changes on data after acceptance do not affect the frame in flight.
- Outputs are registered, with no combinational path from inputs to TX, busy or done.

Test Plan:
- Reset: arst_n=0 for 5 cycles with tx_start=1 -> TX=1, busy=0, done=0 throughout; no frame is started after release while tx_en=0.
- Single byte 0x5A, defaults: tx_en=1, one-cycle tx_start -> the required TX sequence is 0, 0,1,0,1,1,0,1,0, 1, each level lasting 10416 clocks. busy is high for 104160 clocks, and done pulses once at busy fall.
- Loopback: TX wired to the team's UART receiver (rx_en=1), send 0x5A then 0xA5 back-to-back -> receiver reports data=0x5A then 0xA5 with done each and err=0. Transmitter shows only a one-clock idle between frames.
- Ignored requests: tx_start pulsed mid-frame with data=0xFF while sending 0x3C -> frame on the line remains 0x3C, and no second frame follows.
- Parity: PARITY_EN=1, PARITY_ODD=0, send 0x07 -> parity bit 1, frame 11*BIT_PERIOD. With PARITY_ODD=1 -> parity bit 0.
- Abort: assert rst during data bit 3 of 0x5A -> TX=1 and busy=0 at the next edge, with no done pulse. A new tx_start then sends a complete, correct frame.

Source files
------------

// File: rtl/uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : uart_tx                                                         |
// | Brief    : UART transmitter, 8 data bits, optional parity, one stop bit.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module uart_tx #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BAUD       = 9600,
    parameter bit PARITY_EN  = 1'b0,
    parameter bit PARITY_ODD = 1'b0
) (
    input  logic       clk,
    input  logic       arst_n,
    input  logic       rst,
    input  logic       tx_en,
    input  logic       tx_start,
    input  logic [7:0] data,
    output logic       TX,
    output logic       busy,
    output logic       done
);

    localparam int c_BIT_PERIOD = CLK_FREQ / BAUD;
    localparam int c_CNT_W      = (c_BIT_PERIOD > 1) ? $clog2(c_BIT_PERIOD) : 1;
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_BIT_PERIOD - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [2:0] c_IDLE   = 3'd0;
    localparam logic [2:0] c_START  = 3'd1;
    localparam logic [2:0] c_DATA   = 3'd2;
    localparam logic [2:0] c_PARITY = 3'd3;
    localparam logic [2:0] c_STOP   = 3'd4;

    logic [2:0]         r_state, w_state;
    logic [c_CNT_W-1:0] r_cnt, w_cnt;
    logic [2:0]         r_idx, w_idx;
    logic [7:0]         r_shift, w_shift;
    logic               r_parity, w_parity;
    logic               r_tx, w_tx;
    logic               r_busy, w_busy;
    logic               r_done, w_done;
    logic               w_bit_end;

    always_comb begin
        w_state   = r_state;
        w_cnt     = r_cnt;
        w_idx     = r_idx;
        w_shift   = r_shift;
        w_parity  = r_parity;
        w_done    = 1'b0;
        w_bit_end = (r_cnt == c_CNT_LAST);

        case (r_state)
            c_IDLE: begin
                w_cnt = '0;
                w_idx = '0;
                if (tx_start && tx_en) begin
                    w_state  = c_START;
                    w_shift  = data;
                    w_parity = (^data) ^ PARITY_ODD;
                end
            end
            c_START: begin
                w_cnt = w_bit_end ? '0 : r_cnt + c_CNT_ONE;
                if (w_bit_end) w_state = c_DATA;
            end
            c_DATA: begin
                w_cnt = w_bit_end ? '0 : r_cnt + c_CNT_ONE;
                if (w_bit_end) begin
                    if (r_idx == 3'd7) begin
                        w_state = PARITY_EN ? c_PARITY : c_STOP;
                    end else begin
                        w_idx   = r_idx + 3'd1;
                        w_shift = {1'b0, r_shift[7:1]};
                    end
                end
            end
            c_PARITY: begin
                w_cnt = w_bit_end ? '0 : r_cnt + c_CNT_ONE;
                if (w_bit_end) w_state = c_STOP;
            end
            c_STOP: begin
                w_cnt = w_bit_end ? '0 : r_cnt + c_CNT_ONE;
                if (w_bit_end) begin
                    w_state = c_IDLE;
                    w_done  = 1'b1;
                end
            end
            default: begin
                w_state = c_IDLE;
                w_cnt   = '0;
                w_idx   = '0;
            end
        endcase

        // Line level is derived from the upcoming state so TX is a plain flop.
        case (w_state)
            c_START:  w_tx = 1'b0;
            c_DATA:   w_tx = w_shift[0];
            c_PARITY: w_tx = w_parity;
            default:  w_tx = 1'b1;
        endcase
        w_busy = (w_state != c_IDLE);
    end

    always_ff @(posedge clk or negedge arst_n) begin
        if (!arst_n) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else if (rst) begin
            r_state  <= c_IDLE;
            r_cnt    <= '0;
            r_idx    <= '0;
            r_shift  <= '0;
            r_parity <= 1'b0;
            r_tx     <= 1'b1;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_idx    <= w_idx;
            r_shift  <= w_shift;
            r_parity <= w_parity;
            r_tx     <= w_tx;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    assign TX   = r_tx;
    assign busy = r_busy;
    assign done = r_done;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_uart_tx                                                      |
// | Brief    : Self-checking bench for uart_tx with a frame scoreboard.        |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
module tb_uart_tx;

    localparam int c_CLK_FREQ = 160;
    localparam int c_BAUD     = 10;
    localparam int c_BP       = 16;

    typedef struct {
        logic [10:0] bits;
        int          nb;
    } frame_t;

    logic       clk      = 1'b0;
    logic       arst_n   = 1'b0;
    logic       rst      = 1'b0;
    logic       tx_start = 1'b0;
    logic [7:0] data     = 8'h00;
    logic [2:0] en       = 3'b000;
    logic [2:0] w_tx_v, w_busy_v, w_done_v;
    logic       r_tx, r_busy, r_done;

    int     sel         = 0;
    int     n_vec       = 0;
    int     n_mis       = 0;
    int     frames_seen = 0;
    int     last_gap    = 0;
    int     idle_cnt    = 0;
    logic   mon_en      = 1'b1;
    logic   mon_busy    = 1'b0;
    frame_t q[$];

    always #5 clk = ~clk;

    uart_tx #(.CLK_FREQ(c_CLK_FREQ), .BAUD(c_BAUD), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) u_dut (
        .clk(clk), .arst_n(arst_n), .rst(rst), .tx_en(en[0]), .tx_start(tx_start), .data(data),
        .TX(w_tx_v[0]), .busy(w_busy_v[0]), .done(w_done_v[0]));
    uart_tx #(.CLK_FREQ(c_CLK_FREQ), .BAUD(c_BAUD), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) u_dut_pe (
        .clk(clk), .arst_n(arst_n), .rst(rst), .tx_en(en[1]), .tx_start(tx_start), .data(data),
        .TX(w_tx_v[1]), .busy(w_busy_v[1]), .done(w_done_v[1]));
    uart_tx #(.CLK_FREQ(c_CLK_FREQ), .BAUD(c_BAUD), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) u_dut_po (
        .clk(clk), .arst_n(arst_n), .rst(rst), .tx_en(en[2]), .tx_start(tx_start), .data(data),
        .TX(w_tx_v[2]), .busy(w_busy_v[2]), .done(w_done_v[2]));

    always_comb begin
        r_tx   = w_tx_v[sel];
        r_busy = w_busy_v[sel];
        r_done = w_done_v[sel];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic push_frame(input logic [7:0] d, input bit pe, input bit po);
        frame_t f;
        f.bits      = '0;
        f.bits[0]   = 1'b0;
        f.bits[8:1] = d;
        if (pe) begin
            f.bits[9]  = (^d) ^ po;
            f.bits[10] = 1'b1;
            f.nb       = 11;
        end else begin
            f.bits[9]  = 1'b1;
            f.nb       = 10;
        end
        q.push_back(f);
    endtask

    // Entered on the first negedge that shows the start bit.
    task automatic check_frame();
        frame_t e;
        int     bad;
        if (q.size() == 0) begin
            chk("unexpected_frame", 1, 0);
            for (int i = 0; i < 12 * c_BP && r_busy === 1'b1; i++) @(negedge clk);
            return;
        end
        e   = q.pop_front();
        bad = 0;
        for (int b = 0; b < e.nb; b++) begin
            for (int c = 0; c < c_BP; c++) begin
                if (b != 0 || c != 0) @(negedge clk);
                if (r_tx !== e.bits[b] || r_busy !== 1'b1 || r_done !== 1'b0) bad++;
                if (c == c_BP / 2) chk($sformatf("txbit%0d", b), r_tx, e.bits[b]);
            end
        end
        chk("frame_stable_cycles_bad", bad, 0);
        @(negedge clk);
        chk("busy_at_end", r_busy, 0);
        chk("done_at_end", r_done, 1);
        frames_seen++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (mon_en && r_tx === 1'b0) begin
                last_gap = idle_cnt;
                mon_busy = 1'b1;
                check_frame();
                mon_busy = 1'b0;
                idle_cnt = 1;
            end else begin
                idle_cnt++;
                if (r_done !== 1'b0) chk("spurious_done", r_done, 0);
            end
        end
    end

    task automatic send(input logic [7:0] d, input bit pe, input bit po);
        @(negedge clk);
        data     = d;
        tx_start = 1'b1;
        push_frame(d, pe, po);
        @(negedge clk);
        tx_start = 1'b0;
    endtask

    task automatic wait_quiet();
        for (int i = 0; i < 40 * c_BP; i++) begin
            @(negedge clk);
            if (q.size() == 0 && !mon_busy && r_busy === 1'b0) break;
        end
        chk("drain_pending", (q.size() != 0 || mon_busy || r_busy !== 1'b0) ? 1 : 0, 0);
    endtask

    initial begin
        // Reset held with a pending request.
        tx_start = 1'b1;
        en       = 3'b001;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("rst_tx", r_tx, 1);
            chk("rst_busy", r_busy, 0);
            chk("rst_done", r_done, 0);
        end
        en     = 3'b000;
        arst_n = 1'b1;
        repeat (3 * c_BP) @(negedge clk);
        chk("no_frame_while_disabled", r_busy, 0);
        tx_start = 1'b0;
        en       = 3'b001;

        send(8'h5A, 0, 0);
        wait_quiet();

        // Back-to-back: request held through the done cycle, data changed in flight.
        @(negedge clk);
        data     = 8'h5A;
        tx_start = 1'b1;
        push_frame(8'h5A, 0, 0);
        push_frame(8'hA5, 0, 0);
        @(negedge clk);
        data = 8'hA5;
        for (int i = 0; i < 12 * c_BP; i++) begin
            @(negedge clk);
            if (r_done === 1'b1) break;
        end
        @(negedge clk);
        tx_start = 1'b0;
        wait_quiet();
        chk("b2b_idle_gap", last_gap, 1);

        // Request mid-frame ignored; enable dropped mid-frame still completes.
        send(8'h3C, 0, 0);
        repeat (3 * c_BP) @(negedge clk);
        data     = 8'hFF;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        en       = 3'b000;
        wait_quiet();
        repeat (3 * c_BP) @(negedge clk);
        chk("no_second_frame", r_busy, 0);

        sel = 1;
        en  = 3'b010;
        send(8'h07, 1, 0);
        wait_quiet();
        sel = 2;
        en  = 3'b100;
        send(8'h07, 1, 1);
        wait_quiet();

        // Synchronous reset during data bit 3.
        sel    = 0;
        en     = 3'b001;
        mon_en = 1'b0;
        @(negedge clk);
        data     = 8'h5A;
        tx_start = 1'b1;
        @(negedge clk);
        tx_start = 1'b0;
        repeat (4 * c_BP + 2) @(negedge clk);
        chk("abort_pre_bit3", r_tx, 1);
        chk("abort_pre_busy", r_busy, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_tx", r_tx, 1);
        chk("abort_busy", r_busy, 0);
        chk("abort_done", r_done, 0);
        repeat (2 * c_BP) @(negedge clk);
        chk("abort_stays_idle", r_busy, 0);
        mon_en = 1'b1;
        send(8'h5A, 0, 0);
        wait_quiet();

        chk("frames_seen", frames_seen, 7);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
